// File: rtl/sar_ctrl.sv
// -----------------------------------------------------------------------------
// sar_ctrl -- successive-approximation ADC controller.
//
// A start request makes the block track the analog input for SAMPLE_CYC cycles.
// It then performs a binary search over BITW bits, one bit per cycle. It steers
// the DAC through dac_code and reads the comparator on cmp. The finished code
// is published on dout together with a one-cycle done pulse.
//
// Parameters
//   BITW        conversion resolution in bits (matches the downstream DAC)
//   SAMPLE_CYC  number of track/sample cycles per conversion (>= 1)
//
// Ports
//   clk       single clock, rising-edge active
//   rstn      asynchronous active-low reset
//   start     conversion request; ignored while busy
//   cmp       comparator: 1 = analog input >= DAC output (keep trial bit)
//   dac_code  trial code driving the DAC
//   sample    high while the front end tracks the input
//   busy      high during sampling and bit decisions
//   done      one-cycle pulse when dout holds a new result
//   dout      last completed conversion result
// -----------------------------------------------------------------------------
module sar_ctrl #(
   parameter int BITW       = 8,
   parameter int SAMPLE_CYC = 2
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic            cmp,
   output logic [BITW-1:0] dac_code,
   output logic            sample,
   output logic            busy,
   output logic            done,
   output logic [BITW-1:0] dout
);

   localparam int KW = (BITW > 1) ? $clog2(BITW) : 1;
   localparam int CW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

   localparam logic [KW-1:0]   K_TOP    = KW'(BITW - 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(SAMPLE_CYC - 1);
   localparam logic [BITW-1:0] MIDSCALE = BITW'(1) << (BITW - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_CONV,
      ST_DONE
   } state_e;

   state_e          state_q,    state_d;
   logic [CW-1:0]   cnt_q,      cnt_d;
   logic [KW-1:0]   k_q,        k_d;
   logic [BITW-1:0] dac_code_q, dac_code_d;
   logic [BITW-1:0] dout_q,     dout_d;
   logic            sample_q,   sample_d;
   logic            busy_q,     busy_d;
   logic            done_q,     done_d;
   logic [BITW-1:0] bit_mask;

   // Next-state and next-output logic.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      cnt_d      = cnt_q;
      k_d        = k_q;
      dac_code_d = dac_code_q;
      dout_d     = dout_q;
      bit_mask   = BITW'(1) << k_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SAMPLE;
               cnt_d   = '0;
            end
         end

         ST_SAMPLE: begin
            // dac_code holds its prior value while tracking; cmp is ignored.
            if (cnt_q == CNT_LAST) begin
               state_d    = ST_CONV;
               k_d        = K_TOP;
               dac_code_d = MIDSCALE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_CONV: begin
            // Keep or clear trial bit k, then raise bit k-1 as the next trial.
            // Shifting the mask right yields nothing once k reaches 0.
            dac_code_d = (cmp ? dac_code_q : (dac_code_q & ~bit_mask)) | (bit_mask >> 1);
            if (k_q == '0) begin
               state_d = ST_DONE;
               dout_d  = dac_code_d;
            end else begin
               k_d = k_q - 1'b1;
            end
         end

         ST_DONE: begin
            if (start) begin
               state_d = ST_SAMPLE;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Status outputs are registered decodes of the state being entered.
      sample_d = (state_d == ST_SAMPLE);
      busy_d   = sample_d | (state_d == ST_CONV);
      done_d   = (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         k_q        <= K_TOP;
         dac_code_q <= '0;
         dout_q     <= '0;
         sample_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         k_q        <= k_d;
         dac_code_q <= dac_code_d;
         dout_q     <= dout_d;
         sample_q   <= sample_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign dac_code = dac_code_q;
   assign sample   = sample_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign dout     = dout_q;

endmodule

// File: doc/sar_ctrl.md
SAR_CTRL -- requirements
Module: sar_ctrl

Interface
REQ-001 SHALL have parameter BITW, default 8, meaning conversion resolution in bits; it matches the downstream dac BITW.
REQ-002 SHALL have parameter SAMPLE_CYC, default 2, meaning number of track/sample cycles per conversion; legal values are >=1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: conversion request, sampled at the clk rising edge.
REQ-006 SHALL have port cmp, input, 1 bit: comparator result; 1 means analog input >= DAC output, so keep the trial bit.
REQ-007 SHALL have port dac_code, output, BITW bits: trial code driving the dac din.
REQ-008 SHALL have port sample, output, 1 bit: high while the front end tracks the input.
REQ-009 SHALL have port busy, output, 1 bit: high in the SAMPLE and CONV states.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a result is valid.
REQ-011 SHALL have port dout, output, BITW bits: last completed conversion result.

Function
REQ-012 SHALL implement the states IDLE, SAMPLE, CONV and DONE; every output is registered.
REQ-013 IDLE: start=1 at an edge SHALL move the block to SAMPLE; otherwise it SHALL stay in IDLE.
REQ-014 SAMPLE SHALL last exactly SAMPLE_CYC cycles, with sample=1 and busy=1; dac_code holds its prior value; cmp is ignored.
REQ-015 Leaving SAMPLE SHALL enter CONV, with bit index k=BITW-1 and dac_code=2^(BITW-1) (midscale).
REQ-016 Each CONV edge SHALL use cmp to keep (1) or clear (0) bit k, then set bit k-1 if k>0, then decrement k.
REQ-016 (cont.) CONV therefore lasts exactly BITW cycles.
REQ-017 The edge that decides bit 0 SHALL load dout with the final code and enter DONE.
REQ-017 (cont.) dac_code shall equal that final code at the same edge.
REQ-018 DONE SHALL last one cycle, with done=1, busy=0 and sample=0.
REQ-018 (cont.) From DONE, start=1 goes to SAMPLE (back-to-back); otherwise the next state is IDLE.
REQ-019 Latency: done SHALL be high in the cycle following edge SAMPLE_CYC+BITW, counting the start-capturing edge as edge 0.
REQ-019 (cont.) Back-to-back period: SAMPLE_CYC+BITW+1 cycles.
REQ-020 start SHALL be ignored while busy=1; the request is neither queued nor allowed to restart the conversion.
REQ-021 cmp SHALL be ignored outside CONV, including X values.
REQ-022 dac_code SHALL hold the last final code during DONE and IDLE until the next CONV entry.
REQ-023 dout SHALL change only at the edge entering DONE; it holds between conversions.
REQ-024 Arithmetic SHALL be unsigned BITW bits, with no wrap; all-ones cmp yields 2^BITW-1 and all-zeros cmp yields 0.

Reset
REQ-025 rstn=0 SHALL immediately force: state=IDLE, dac_code=0, dout=0, sample=0, busy=0, done=0, k=BITW-1.
REQ-026 Reset mid-SAMPLE or mid-CONV SHALL abort the conversion with no done pulse and dout=0.
REQ-027 After rstn rises, the first edge with start=1 SHALL begin a normal conversion.

Verification (BITW=8, SAMPLE_CYC=2)
REQ-028 Reset check: assert rstn=0 at any time -> all outputs 0 within the same timestep; state IDLE.
REQ-029 Ideal comparator, input code 0xA5, start pulse:
- sample is high for 2 cycles.
- dac_code steps 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
- done is high in the cycle after edge 10, with dout=0xA5.
REQ-030 cmp stuck at 1 -> dout=0xFF; cmp stuck at 0 -> dout=0x00; both with done timing as in REQ-029.
REQ-031 start held high for 3 conversions -> done pulses exactly 11 cycles apart; busy low only in the DONE cycles.
REQ-032 Extra start pulses during SAMPLE and CONV -> no timing change, no extra done, correct dout.
REQ-033 rstn pulsed low during the 4th CONV cycle -> no done, dout=0; a subsequent start converts 0x3C correctly.
